mult4_seq: RTL and testbench



---
 rtl/mult4_seq.sv | 55 +++++
 tb/tb_mult4_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/mult4_seq.sv
// mult4_seq: sequential 4x4 unsigned shift-and-add multiplier driving an external carry-select adder; optional MULT4_ZERO_SKIP_EN
module mult4_seq (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [3:0] MA,
  input  logic [3:0] MB,
  output logic       Ready,
  output logic       Done,
  output logic [7:0] P,
  output logic [3:0] AddA,
  output logic [3:0] AddB,
  output logic       AddC,
  input  logic [3:0] AddS,
  input  logic       AddCOut
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state, cnt;
  logic [3:0] mcand, hi, lo;
  logic skip;
`ifdef MULT4_ZERO_SKIP_EN
  assign skip = (MA == 4'h0) || (MB == 4'h0);
`else
  assign skip = 1'b0;
`endif
  assign Ready = state == IDLE;
  assign Done  = state == DONE;
  assign P     = {hi, lo};
  assign AddA  = hi;
  assign AddB  = lo[0] ? mcand : 4'h0;
  assign AddC  = 1'b0;
  // A zero operand loads an all-zero product with cnt at its last value, so one zero-add pass lands in DONE a cycle later
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      mcand <= 4'h0;
      hi    <= 4'h0;
      lo    <= 4'h0;
      cnt   <= 2'd0;
    end else if (state == IDLE) begin
      if (Start) begin
        state <= RUN;
        mcand <= MA;
        hi    <= 4'h0;
        lo    <= skip ? 4'h0 : MB;
        cnt   <= skip ? 2'd3 : 2'd0;
      end
    end else if (state == RUN) begin
      {hi, lo} <= {AddCOut, AddS, lo[3:1]};
      cnt      <= cnt + 2'd1;
      if (cnt == 2'd3) state <= DONE;
    end else begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_mult4_seq.sv
// tb_mult4_seq: directed bench for mult4_seq with a cycle-age product model and a literal-pinned operation list
module tb_mult4_seq;
  logic       CLK = 1'b0;
  logic       RST, Start;
  logic [3:0] MA, MB, AddA, AddB, AddS;
  logic       Ready, Done, AddC, AddCOut;
  logic [7:0] P;
  int checks = 0, errors = 0;
  bit armed = 1'b0;
`ifdef MULT4_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  always #5 CLK = ~CLK;
  // stand-in for the carry-select adder
  assign {AddCOut, AddS} = 5'(AddA) + 5'(AddB) + 5'(AddC);
  mult4_seq dut (
    .CLK(CLK), .RST(RST), .Start(Start), .MA(MA), .MB(MB),
    .Ready(Ready), .Done(Done), .P(P),
    .AddA(AddA), .AddB(AddB), .AddC(AddC), .AddS(AddS), .AddCOut(AddCOut)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  // model: age counts edges since an accepted Start, -1 when idle
  int age = -1, lat = 4;
  logic [3:0] m_a = 4'h0, m_b = 4'h0;
  logic [7:0] m_p = 8'h00;
  always @(posedge CLK)
    if (RST) begin
      age <= -1;
      m_p <= 8'h00;
    end else if (age < 0) begin
      if (Start) begin
        age <= 0;
        m_a <= MA;
        m_b <= MB;
        m_p <= 8'(MA) * 8'(MB);
        lat <= (SKIP && (MA == 4'h0 || MB == 4'h0)) ? 1 : 4;
      end
    end else begin
      age <= (age == lat) ? -1 : age + 1;
    end
  always @(negedge CLK)
    if (armed) begin
      chk("ready", 32'(Ready), 32'(age < 0));
      chk("done", 32'(Done), 32'(age == lat));
      chk("addc", 32'(AddC), 32'd0);
      if (age < 0 || age == lat) chk("p_hold", 32'(P), 32'(m_p));
      if (age >= 0 && age < lat && lat == 4) chk("addb", 32'(AddB), 32'(m_b[age] ? m_a : 4'h0));
    end
  task automatic wait_done(input int exp_lat, input logic [7:0] exp_p);
    int n = 0;
    while (!Done && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("p_lit", 32'(P), 32'(exp_p));
  endtask
  task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp_p, input int exp_lat);
    Start = 1'b1; MA = a; MB = b;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(exp_lat, exp_p);
    @(posedge CLK); #1;
  endtask
  initial begin
    RST = 1'b1; Start = 1'b0; MA = 4'h0; MB = 4'h0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    armed = 1'b1;
    chk("rst_p", 32'(P), 32'h00);
    chk("rst_ready", 32'(Ready), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_adda", 32'(AddA), 32'h0);
    chk("rst_addb", 32'(AddB), 32'h0);
    run(4'hD, 4'hC, 8'h9C, 4);
    run(4'hF, 4'hF, 8'hE1, 4);
    run(4'h0, 4'h9, 8'h00, SKIP ? 1 : 4);
    run(4'hA, 4'h5, 8'h32, 4);
    Start = 1'b1; MA = 4'h3; MB = 4'h5;
    @(posedge CLK); #1;
    MA = 4'h7; MB = 4'h7;
    wait_done(4, 8'h0F);
    @(posedge CLK); #1;
    chk("held_ready", 32'(Ready), 32'd1);
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(4, 8'h31);
    @(posedge CLK); #1;
    Start = 1'b1; MA = 4'h9; MB = 4'h6;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_ready", 32'(Ready), 32'd1);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_p", 32'(P), 32'h00);
    chk("abort_addb", 32'(AddB), 32'h0);
    run(4'h9, 4'h6, 8'h36, 4);
    repeat (3) @(posedge CLK);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
